// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for a reg64-based register file: round-robin arbitration,
// one-hot enables two cycles ahead of commit, commit-aligned WriteData and in-flight forwarding.

module regfile_wr_sched_fwd_lane #(
  parameter int AW = 5
) (
  input  logic          i_vld,
  input  logic          i_live,
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_hit
);
  assign o_hit = i_vld & i_live & (i_addr == i_rd_addr);
endmodule

module regfile_wr_sched #(
  parameter int NREQ = 4,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    wr_en,
  output logic [DW-1:0]      wr_data,
  output logic [NREQ-1:0]    done,
  input  logic [AW-1:0]      rd_addr,
  output logic               fwd_hit,
  output logic [DW-1:0]      fwd_data
);
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int STAGES = 3;
  localparam logic [NREG-1:0] ONE_REG = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0] ONE_REQ = {{(NREQ-1){1'b0}}, 1'b1};

  // live = address maps to a writable register (not XZR, not out of range)
  typedef struct packed {
    logic          live;
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stg_t;

  logic [IW-1:0]     r_ptr;
  logic [STAGES:1]   r_vld_pipe;
  stg_t              r_stg [1:STAGES];
  logic [NREG-1:0]   r_wr_en;
  logic [DW-1:0]     r_wr_data;
  logic [NREQ-1:0]   r_done;

  logic              w_win_vld;
  logic [IW-1:0]     w_win_idx;
  stg_t              w_win;
  logic [STAGES:1]   w_hit;

  // Rotating priority search starting at r_ptr
  always_comb begin
    int j;
    j         = 0;
    gnt       = '0;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_win_vld && req[j]) begin
        w_win_vld = 1'b1;
        w_win_idx = IW'(j);
      end
    end
    if (w_win_vld) gnt[w_win_idx] = 1'b1;
  end

  always_comb begin
    w_win      = '0;
    w_win.idx  = w_win_idx;
    w_win.addr = req_addr[w_win_idx*AW +: AW];
    w_win.data = req_data[w_win_idx*DW +: DW];
    w_win.live = int'(w_win.addr) < (NREG - 1);
  end

  // Enable is registered off the winner so it lands in the cycle S1 holds it;
  // data/done are registered off S2 so they land in the cycle S3 holds it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr      <= '0;
      r_vld_pipe <= '0;
      for (int s = 1; s <= STAGES; s++) r_stg[s] <= '0;
      r_wr_en    <= '0;
      r_wr_data  <= '0;
      r_done     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_win_vld};
      r_stg[1]   <= w_win;
      for (int s = 2; s <= STAGES; s++) r_stg[s] <= r_stg[s-1];
      r_wr_en    <= (w_win_vld && w_win.live) ? (ONE_REG << w_win.addr) : '0;
      r_wr_data  <= r_vld_pipe[STAGES-1] ? r_stg[STAGES-1].data : '0;
      r_done     <= r_vld_pipe[STAGES-1] ? (ONE_REQ << r_stg[STAGES-1].idx) : '0;
      if (w_win_vld)
        r_ptr <= (w_win_idx == IW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
    end
  end

  for (genvar s = 1; s <= STAGES; s++) begin : g_fwd
    regfile_wr_sched_fwd_lane #(.AW(AW)) u_lane (
      .i_vld     (r_vld_pipe[s]),
      .i_live    (r_stg[s].live),
      .i_addr    (r_stg[s].addr),
      .i_rd_addr (rd_addr),
      .o_hit     (w_hit[s])
    );
  end

  // Oldest first so the youngest match (S1) overrides
  always_comb begin
    fwd_data = '0;
    for (int s = STAGES; s >= 1; s--)
      if (w_hit[s]) fwd_data = r_stg[s].data;
    fwd_hit = |w_hit;
  end

  assign wr_en   = r_wr_en;
  assign wr_data = r_wr_data;
  assign done    = r_done;

endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Write-port scheduler for a register file built from reg64 cells.
- Each reg64 applies its write enable two clocks after assertion and samples WriteData only in that commit cycle.
- This block round-robin arbitrates NREQ writers and issues one-hot per-register enables. It drives the shared WriteData bus aligned to each commit cycle, and forwards in-flight write data so reads never see stale values.

Parameters:
- NREQ, 4, number of write requesters.
- NREG, 32, registers in the file; register NREG-1 is hard-wired zero (XZR).
- AW, 5, address width; must satisfy 2**AW >= NREG.
- DW, 64, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- req  in  NREQ  request per requester.
- req_addr  in  NREQ*AW  destination register; requester i uses slice [i*AW +: AW].
- req_data  in  NREQ*DW  write data; requester i uses slice [i*DW +: DW].
- gnt  out  NREQ  combinational one-hot accept in the current cycle; at most one bit set.
- wr_en  out  NREG  registered one-hot; connects to reg64 wrEnable of each register.
- wr_data  out  DW  registered; connects to WriteData of every reg64.
- done  out  NREQ  registered one-cycle pulse in the commit cycle of requester i's write.
- rd_addr  in  AW  forwarding query address.
- fwd_hit  out  1  combinational; rd_addr matches an in-flight write.
- fwd_data  out  DW  combinational; data of youngest matching in-flight write, 0 when no hit.

Behaviour:
- Pipeline:
  - Stages S1, S2, S3, each holding {valid, idx, addr, data}.
  - S1 captures the winner on the edge ending its grant cycle t; S1→S2→S3 every edge, no stall.
- Issue timing (all registered outputs):
  - wr_en[addr] = 1 during t+1 (S1 valid, addr ≠ NREG-1); all other bits 0.
  - Commit cycle is t+3: wr_data = S3.data and done[S3.idx] = 1. When S3 is not valid, wr_data = 0 and done = 0.
  - Register holds new value from cycle t+4.
- Throughput: one accept per cycle. Back-to-back writes are legal, including to the same address; the later one wins.
- Arbitration:
  - Round-robin pointer ptr; search starts at ptr, and the first asserted req wins.
  - On a grant to i, ptr ← (i+1) mod NREQ. With no request, ptr holds.
  - gnt depends on req and ptr only, not on address.
- Requester rule: hold req/addr/data until the cycle in which gnt[i] = 1. The next cycle it may present a new write or drop req.
- XZR: a write to NREG-1 is granted and flows through with done pulsed, but no wr_en bit is set and it never causes fwd_hit.
- Address ≥ NREG (other than NREG-1): treated as a no-op in the same way as XZR.
- Forwarding:
  - Priority S1 > S2 > S3 (youngest first). A write is in flight from S1 through S3 inclusive.
  - Same-cycle bypass from the granted request is not provided.
- Reset values: ptr = 0, all stage valids = 0, wr_en = 0, wr_data = 0, done = 0.
- Reset mid-operation:
  - In-flight entries are discarded and no done is pulsed.
  - reg64 internal delay flops are not reset, so an enable issued before reset still commits. It commits wr_data = 0 during reset, or the then-current S3 data after reset. This is accepted behaviour; software reinitialises registers after reset.
- Simultaneous requests: exactly one grant; losers keep req asserted and are served in rotation within NREQ cycles.

Test Plan:
- Single write: req[0] with addr 5, data 64'h00000000000000FF in cycle 0 → gnt[0] in cycle 0; wr_en[5] in cycle 1; wr_data = FF and done[0] in cycle 3; register 5 = FF from cycle 4.
- Contention: req = 4'b1111 held after reset → gnt order 0,1,2,3,0; each requester granted once per 4 cycles; done pulses follow in the same order 3 cycles later.
- Back-to-back same address: addr 7 with data AA in cycle 0, then addr 7 with data BB in cycle 1 → register 7 = AA in cycle 4 and BB from cycle 5. With rd_addr = 7 in cycle 2, fwd_data = BB and fwd_hit = 1.
- XZR: write of 64'hFFFF to addr 31 → granted, done pulses, all wr_en stay 0, fwd_hit = 0 for rd_addr = 31.
- Forward miss/hit window: write addr 3 with data 64'h1234 granted in cycle 0, rd_addr = 3 → fwd_hit = 0 in cycle 0, 1 in cycles 1–3, 0 from cycle 4.
- Async reset in cycle 2 of a write to addr 9 → outputs clear immediately; no done pulses; register 9 receives 0 at its commit edge; ptr restarts at 0.
